fosfor_present_ctrl: RTL and testbench

Control and sequencing block for the PRESENT-80 encryption datapath on the TinyTapeout nibble bus. It decodes the 2-bit address / 4-bit data bus into commands, byte-assembles register writes and register reads, and drives the round sequence of the PRESENT datapath. Those round-sequence outputs are load, 31 rounds and a final key addition. It sits between `fosfor_present_top`'s pin unpacking and the datapath/register file, and owns the status byte.

---
 rtl/fosfor_present_ctrl.sv | 156 +++++++++++++++
 tb/tb_fosfor_present_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fosfor_present_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fosfor_present_ctrl                                       |
// | Desc     : PRESENT-80 bus decoder, register access and round         |
// |            sequencer. Define FOSFOR_TEST_REG_EN for a scratch reg    |
// |            at 0x08.                                                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fosfor_present_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic       Clk_k,
  input  logic       Reset_rn,
  input  logic [1:0] Address_b,
  input  logic [3:0] DataIn_b,
  output logic [7:0] DataOut_b,
  output logic [7:0] RegAddr_b,
  output logic [7:0] RegWData_b,
  output logic       RegWe,
  input  logic [7:0] RegRData_b,
  output logic       Load,
  output logic       RoundEn,
  output logic [4:0] Round_b,
  output logic       Final
);

  localparam logic [1:0] c_ADDR_IDLE         = 2'b00;
  localparam logic [1:0] c_ADDR_CMD          = 2'b01;
  localparam logic [1:0] c_ADDR_LOW          = 2'b10;
  localparam logic [1:0] c_ADDR_HIGH         = 2'b11;
  localparam logic [3:0] c_CMD_LATCH_ADDRESS = 4'h1;
  localparam logic [3:0] c_CMD_WRITE         = 4'h2;
  localparam logic [3:0] c_CMD_START         = 4'h3;
  localparam logic [3:0] c_CMD_CLEAR         = 4'h4;
  localparam logic [4:0] c_ROUNDS            = 5'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_round, w_round_nxt;
  logic [7:0] r_data;
  logic [7:0] r_addr;
  logic       r_err;
  logic       r_done;
  logic       r_out_sel;
  logic       r_we;

  logic       w_is_cmd;
  logic       w_cmd_latch;
  logic       w_cmd_write;
  logic       w_cmd_start;
  logic       w_cmd_clear;
  logic       w_idle;
  logic       w_scratch_hit;
  logic       w_err_set;
  logic [7:0] w_status;
  logic [7:0] w_rdata;

  assign w_is_cmd    = (Address_b == c_ADDR_CMD);
  assign w_cmd_latch = w_is_cmd && (DataIn_b == c_CMD_LATCH_ADDRESS);
  assign w_cmd_write = w_is_cmd && (DataIn_b == c_CMD_WRITE);
  assign w_cmd_start = w_is_cmd && (DataIn_b == c_CMD_START);
  assign w_cmd_clear = w_is_cmd && (DataIn_b == c_CMD_CLEAR);
  assign w_idle      = (r_state == S_IDLE);
  // Scratch writes are legal in any state, so they never count as a busy write.
  assign w_err_set   = (w_cmd_write && !w_idle && !w_scratch_hit) ||
                       (w_cmd_start && !w_idle);

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    Load        = 1'b0;
    RoundEn     = 1'b0;
    Final       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        Load        = 1'b1;
        w_state_nxt = S_ROUND;
        w_round_nxt = 5'd1;
      end
      S_ROUND: begin
        RoundEn = 1'b1;
        if (r_round == c_ROUNDS) w_state_nxt = S_FINAL;
        else                     w_round_nxt = r_round + 5'd1;
      end
      S_FINAL: begin
        Final       = 1'b1;
        w_state_nxt = S_IDLE;
        w_round_nxt = 5'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk_k) begin
    if (!Reset_rn) begin
      r_state   <= S_IDLE;
      r_round   <= 5'd0;
      r_data    <= 8'h00;
      r_addr    <= 8'h00;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_out_sel <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_round   <= w_round_nxt;
      r_out_sel <= (Address_b == c_ADDR_LOW);
      if (Address_b == c_ADDR_LOW)  r_data[3:0] <= DataIn_b;
      if (Address_b == c_ADDR_HIGH) r_data[7:4] <= DataIn_b;
      if (w_cmd_latch) r_addr <= r_data;
      r_we <= w_cmd_write && w_idle && !w_scratch_hit;
      if (w_cmd_clear)    r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (r_state == S_FINAL)         r_done <= 1'b1;
      else if (w_cmd_start && w_idle) r_done <= 1'b0;
    end
  end

`ifdef FOSFOR_TEST_REG_EN
  localparam logic [7:0] c_SCRATCH_ADDR = 8'h08;
  logic [7:0] r_scratch;

  assign w_scratch_hit = (r_addr == c_SCRATCH_ADDR);
  assign w_rdata       = w_scratch_hit ? r_scratch : RegRData_b;

  always_ff @(posedge Clk_k) begin
    if (!Reset_rn)                         r_scratch <= 8'h00;
    else if (w_cmd_write && w_scratch_hit) r_scratch <= r_data;
  end
`else
  assign w_scratch_hit = 1'b0;
  assign w_rdata       = RegRData_b;
`endif

  // Round number is only exposed while rounds are running.
  assign Round_b    = RoundEn ? r_round : 5'd0;
  assign w_status   = {Round_b, r_done, r_err, w_idle};
  assign DataOut_b  = r_out_sel ? w_rdata : w_status;
  assign RegAddr_b  = r_addr;
  assign RegWData_b = r_data;
  assign RegWe      = r_we;

endmodule
`default_nettype wire

// File: tb/tb_fosfor_present_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fosfor_present_ctrl                                    |
// | Desc     : Scoreboard bench for fosfor_present_ctrl (random + plan). |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fosfor_present_ctrl;
  localparam int ROUNDS = 31;
  localparam logic [1:0] A_IDLE = 2'b00, A_CMD = 2'b01, A_LOW = 2'b10, A_HIGH = 2'b11;

  logic       Clk_k = 1'b0;
  logic       Reset_rn = 1'b0;
  logic [1:0] Address_b = A_IDLE;
  logic [3:0] DataIn_b = 4'h0;
  logic [7:0] DataOut_b, RegAddr_b, RegWData_b, RegRData_b;
  logic       RegWe, Load, RoundEn, Final;
  logic [4:0] Round_b;

  fosfor_present_ctrl #(.ROUNDS(ROUNDS)) dut (
    .Clk_k(Clk_k), .Reset_rn(Reset_rn), .Address_b(Address_b), .DataIn_b(DataIn_b),
    .DataOut_b(DataOut_b), .RegAddr_b(RegAddr_b), .RegWData_b(RegWData_b), .RegWe(RegWe),
    .RegRData_b(RegRData_b), .Load(Load), .RoundEn(RoundEn), .Round_b(Round_b), .Final(Final)
  );

  always #5 Clk_k = ~Clk_k;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Register-file stand-in: written on RegWe, read combinationally.
  logic [7:0] env_regs [256];
  logic       env_init = 1'b0;
  always @(posedge Clk_k) begin
    if (!env_init) begin
      for (int i = 0; i < 256; i++) env_regs[i] <= init_val(i);
      env_init <= 1'b1;
    end else if (RegWe === 1'b1) begin
      env_regs[RegAddr_b] <= RegWData_b;
    end
  end
  assign RegRData_b = env_regs[RegAddr_b];

  // Reference model: transaction-level view of the bus and sequence timing.
  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        wq[$];
  int         lq[$];
  int         fq[$];
  int         cyc = 0;
  bit         m_has_start = 0;
  int         m_s = 0;
  bit         m_err = 0;
  bit         m_sel = 0;
  logic [7:0] m_data = 8'h00, m_addr = 8'h00, m_scratch = 8'h00;
  logic [7:0] m_regs [256];
  bit         mon_en = 0;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit scratch_addr(input logic [7:0] a);
`ifdef FOSFOR_TEST_REG_EN
    return a == 8'h08;
`else
    return (a == 8'h08) && 1'b0;
`endif
  endfunction

  task automatic step(input logic [1:0] a, input logic [3:0] d, input logic rn);
    bit busy_prev;
    Address_b = a; DataIn_b = d; Reset_rn = rn;
    @(posedge Clk_k);
    busy_prev = m_has_start && ((cyc - m_s) <= ROUNDS + 1);
    cyc++;
    if (!rn) begin
      m_has_start = 0; m_err = 0; m_sel = 0;
      m_data = 8'h00; m_addr = 8'h00; m_scratch = 8'h00;
      wq.delete(); lq.delete(); fq.delete();
    end else begin
      m_sel = (a == A_LOW);
      case (a)
        A_LOW:  m_data[3:0] = d;
        A_HIGH: m_data[7:4] = d;
        A_CMD: begin
          case (d)
            4'h1: m_addr = m_data;
            4'h2: begin
              if (scratch_addr(m_addr)) m_scratch = m_data;
              else if (busy_prev) m_err = 1;
              else begin
                wq.push_back('{cyc, m_addr, m_data});
                m_regs[m_addr] = m_data;
              end
            end
            4'h3: begin
              if (busy_prev) m_err = 1;
              else begin
                m_has_start = 1; m_s = cyc;
                lq.push_back(cyc); fq.push_back(cyc + ROUNDS + 1);
              end
            end
            4'h4: m_err = 0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    step(A_LOW, a[3:0], 1); step(A_HIGH, a[7:4], 1); step(A_CMD, 4'h1, 1);
    step(A_LOW, v[3:0], 1); step(A_HIGH, v[7:4], 1); step(A_CMD, 4'h2, 1);
  endtask

  task automatic rd(input logic [7:0] a);
    step(A_LOW, a[3:0], 1); step(A_HIGH, a[7:4], 1); step(A_CMD, 4'h1, 1);
    step(A_LOW, 4'h0, 1); step(A_IDLE, 4'h0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(A_IDLE, 4'h0, 1);
  endtask

  // Monitor: compares every observable output against the model each cycle.
  always @(negedge Clk_k) begin
    int ph; bit busy, done, exp_ev;
    logic [4:0] er; logic [7:0] st, rdv, exp_do;
    if (mon_en) begin
      ph   = cyc - m_s;
      busy = m_has_start && ph <= ROUNDS + 1;
      done = m_has_start && ph >= ROUNDS + 2;
      er   = (m_has_start && ph >= 1 && ph <= ROUNDS) ? 5'(ph) : 5'd0;
      st   = {er, done, m_err, !busy};
      rdv  = scratch_addr(m_addr) ? m_scratch : m_regs[m_addr];
      exp_do = m_sel ? rdv : st;
      chk("round", 16'(Round_b), 16'(er));
      chk("round_en", 16'(RoundEn), 16'(er != 5'd0));
      chk("dout", 16'(DataOut_b), 16'(exp_do));

      while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
      exp_ev = (wq.size() > 0 && wq[0].cyc == cyc);
      chk("regwe", 16'(RegWe), 16'(exp_ev));
      if (exp_ev && RegWe === 1'b1) begin
        chk("wr_addr", 16'(RegAddr_b), 16'(wq[0].a));
        chk("wr_data", 16'(RegWData_b), 16'(wq[0].d));
        void'(wq.pop_front());
      end

      while (lq.size() > 0 && lq[0] < cyc) void'(lq.pop_front());
      exp_ev = (lq.size() > 0 && lq[0] == cyc);
      chk("load", 16'(Load), 16'(exp_ev));
      if (exp_ev) void'(lq.pop_front());

      while (fq.size() > 0 && fq[0] < cyc) void'(fq.pop_front());
      exp_ev = (fq.size() > 0 && fq[0] == cyc);
      chk("final", 16'(Final), 16'(exp_ev));
      if (exp_ev) void'(fq.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) m_regs[i] = init_val(i);
    step(A_IDLE, 4'h0, 0);
    mon_en = 1;
    step(A_IDLE, 4'h0, 0);
    idle(2);

    // Key and plaintext of zero, then a full encryption sequence.
    for (int i = 8'h10; i <= 8'h19; i++) wr(8'(i), 8'h00);
    for (int i = 0; i <= 7; i++) wr(8'(i), 8'h00);
    rd(8'h12); rd(8'h03);
    step(A_CMD, 4'h3, 1);
    idle(40);

    // Illegal write and restart during rounds, then clear.
    step(A_CMD, 4'h3, 1);
    idle(5);
    wr(8'h33, 8'h44);
    step(A_CMD, 4'h3, 1);
    idle(2);
    step(A_CMD, 4'h4, 1);
    rd(8'h05);
    idle(30);

    // Start sampled on the edge that leaves FINAL must be rejected.
    step(A_CMD, 4'h3, 1);
    idle(ROUNDS + 1);
    step(A_CMD, 4'h3, 1);
    idle(3);
    step(A_CMD, 4'h4, 1);

    // Reset while round 10 is active.
    step(A_CMD, 4'h3, 1);
    idle(10);
    step(A_IDLE, 4'h0, 0);
    idle(3);

    // Address 0x08: scratch register or forwarded write depending on build.
    wr(8'h08, 8'hA5);
    idle(1);
    rd(8'h08);

    // Randomised bus traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] a; logic [3:0] d; logic rn;
      a  = 2'($urandom_range(0, 3));
      d  = (a == A_CMD) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 199) != 0);
      step(a, d, rn);
    end

    idle(ROUNDS + 4);
    chk("wq_drained", 16'(wq.size()), 16'd0);
    chk("lq_drained", 16'(lq.size()), 16'd0);
    chk("fq_drained", 16'(fq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
